// File: rtl/branch_resolve_unit.sv
// Branch/jump resolve stage.
//   Issue (cycle N) -> E1 register (N+1) -> registered outputs (N+2).
//   E1 evaluates condition, target and link (PC+4), and compares the outcome
//   against the fetch-time prediction. The outputs are the link writeback,
//   the predictor update, and a mispredict flush/redirect held FLUSH_HOLD cycles.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   issue_valid, RS_BR_*    issue port from the branch reservation station
//   immediate_BR, Operand*  offset and source operands
//   PC_BR                   instruction PC
//   BR_result*              link writeback (JAL/JALR with a non-zero destination)
//   BR_inst_num             program-order tag of the instruction resolved this cycle
//   BPU_update_*            predictor update (one strobe per resolved instruction)
//   BR_mispredict           flush request to fetch/rename
//   BR_redirect_PC          correct next PC, stable while BR_mispredict is high
module branch_resolve_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PHY_W      = 8,
  parameter int unsigned FLUSH_HOLD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             RS_BR_Branch,
  input  logic             RS_BR_Jump,
  input  logic             RS_BR_Jalr,
  input  logic             RS_BR_Hit,
  input  logic             RS_BR_taken,
  input  logic [PHY_W-1:0] RS_BR_Phy,
  input  logic [31:0]      RS_BR_inst_num_output,
  input  logic [2:0]       RS_BR_funct3,
  input  logic [XLEN-1:0]  immediate_BR,
  input  logic [XLEN-1:0]  Operand1_BR,
  input  logic [XLEN-1:0]  Operand2_BR,
  input  logic [XLEN-1:0]  PC_BR,
  output logic [XLEN-1:0]  BR_result,
  output logic [PHY_W-1:0] BR_result_dest,
  output logic             BR_result_valid,
  output logic [31:0]      BR_inst_num,
  output logic             BPU_update_valid,
  output logic [XLEN-1:0]  BPU_update_PC,
  output logic             BPU_update_taken,
  output logic [XLEN-1:0]  BPU_update_target,
  output logic             BR_mispredict,
  output logic [XLEN-1:0]  BR_redirect_PC
);

  localparam int unsigned TAG_W = 32;
  localparam int unsigned CNT_W = (FLUSH_HOLD < 2) ? 1 : $clog2(FLUSH_HOLD + 1);

  typedef struct packed {
    logic             branch;
    logic             jump;
    logic             jalr;
    logic             hit;
    logic             pred_taken;
    logic [PHY_W-1:0] phy;
    logic [TAG_W-1:0] tag;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [XLEN-1:0]  pc;
  } br_op_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;
  logic [TAG_W-1:0] flush_tag;

  br_op_t           issue_op;
  br_op_t           e1_op;
  logic             e1_valid;

  logic             flushing;
  logic             e1_live_c;
  logic             cond_c;
  logic             taken_c;
  logic             mp_c;
  logic [XLEN-1:0]  target_c;
  logic [XLEN-1:0]  link_c;
  logic [XLEN-1:0]  redirect_c;
  logic             kill_en_c;
  logic [TAG_W-1:0] kill_tag_c;
  logic             accept_c;

  logic             mispredict_d;
  logic [XLEN-1:0]  redirect_d;
  logic [TAG_W-1:0] flush_tag_d;

  // Pack the issue port into one payload for the E1 register.
  always_comb begin
    issue_op            = '0;
    issue_op.branch     = RS_BR_Branch;
    issue_op.jump       = RS_BR_Jump;
    issue_op.jalr       = RS_BR_Jalr;
    issue_op.hit        = RS_BR_Hit;
    issue_op.pred_taken = RS_BR_taken;
    issue_op.phy        = RS_BR_Phy;
    issue_op.tag        = RS_BR_inst_num_output;
    issue_op.funct3     = RS_BR_funct3;
    issue_op.imm        = immediate_BR;
    issue_op.op1        = Operand1_BR;
    issue_op.op2        = Operand2_BR;
    issue_op.pc         = PC_BR;
  end

  // E1 evaluation: condition, direction, target, link and prediction check.
  always_comb begin
    flushing  = (state == FLUSH);
    // Anything younger than the active flush tag is wrong-path.
    e1_live_c = e1_valid & ~(flushing & (e1_op.tag > flush_tag));

    cond_c = 1'b0;
    case (e1_op.funct3)
      3'b000:  cond_c = (e1_op.op1 == e1_op.op2);
      3'b001:  cond_c = (e1_op.op1 != e1_op.op2);
      3'b100:  cond_c = ($signed(e1_op.op1) <  $signed(e1_op.op2));
      3'b101:  cond_c = ($signed(e1_op.op1) >= $signed(e1_op.op2));
      3'b110:  cond_c = (e1_op.op1 <  e1_op.op2);
      3'b111:  cond_c = (e1_op.op1 >= e1_op.op2);
      default: cond_c = 1'b0;
    endcase

    taken_c = e1_op.jump | (e1_op.branch & cond_c);

    if (e1_op.jump && e1_op.jalr) begin
      target_c = (e1_op.op1 + e1_op.imm) & ~XLEN'(1);
    end else begin
      target_c = e1_op.pc + e1_op.imm;
    end

    link_c     = e1_op.pc + XLEN'(4);
    redirect_c = taken_c ? target_c : link_c;
    mp_c       = e1_live_c & (taken_c != (e1_op.hit & e1_op.pred_taken));
  end

  // Issue filter: a same-cycle mispredict supplies the kill tag, otherwise
  // the latched flush tag applies while flushing.
  always_comb begin
    kill_en_c  = mp_c | flushing;
    kill_tag_c = mp_c ? e1_op.tag : flush_tag;
    accept_c   = issue_valid & (RS_BR_Branch | RS_BR_Jump) &
                 ~(kill_en_c & (RS_BR_inst_num_output > kill_tag_c));
  end

  // E1 pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      e1_valid <= 1'b0;
      e1_op    <= '0;
    end else begin
      e1_valid <= accept_c;
      if (accept_c) begin
        e1_op <= issue_op;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // FSM next state; a mispredict while flushing is always older and reloads the hold.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    case (state)
      IDLE: begin
        if (mp_c) begin
          state_next    = FLUSH;
          hold_cnt_next = CNT_W'(FLUSH_HOLD);
        end
      end
      FLUSH: begin
        if (mp_c) begin
          hold_cnt_next = CNT_W'(FLUSH_HOLD);
        end else if (hold_cnt <= CNT_W'(1)) begin
          state_next    = IDLE;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  // FSM outputs: flush flag, redirect and flush tag for the next cycle.
  always_comb begin
    mispredict_d = (state_next == FLUSH);
    redirect_d   = BR_redirect_PC;
    flush_tag_d  = flush_tag;
    if (mp_c) begin
      redirect_d  = redirect_c;
      flush_tag_d = e1_op.tag;
    end
  end

  // Output registers: strobes for one cycle, data held until the next resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      BR_result         <= '0;
      BR_result_dest    <= '0;
      BR_result_valid   <= 1'b0;
      BR_inst_num       <= '0;
      BPU_update_valid  <= 1'b0;
      BPU_update_PC     <= '0;
      BPU_update_taken  <= 1'b0;
      BPU_update_target <= '0;
      BR_mispredict     <= 1'b0;
      BR_redirect_PC    <= '0;
      flush_tag         <= '0;
    end else begin
      BR_result_valid  <= e1_live_c & e1_op.jump & (e1_op.phy != '0);
      BPU_update_valid <= e1_live_c;
      BR_mispredict    <= mispredict_d;
      BR_redirect_PC   <= redirect_d;
      flush_tag        <= flush_tag_d;
      if (e1_live_c) begin
        BR_result         <= link_c;
        BR_result_dest    <= e1_op.phy;
        BR_inst_num       <= e1_op.tag;
        BPU_update_PC     <= e1_op.pc;
        BPU_update_taken  <= taken_c;
        BPU_update_target <= target_c;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PHY_W = 8;
  localparam int          HOLD  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic             RS_BR_Branch, RS_BR_Jump, RS_BR_Jalr, RS_BR_Hit, RS_BR_taken;
  logic [PHY_W-1:0] RS_BR_Phy;
  logic [31:0]      RS_BR_inst_num_output;
  logic [2:0]       RS_BR_funct3;
  logic [XLEN-1:0]  immediate_BR, Operand1_BR, Operand2_BR, PC_BR;
  logic [XLEN-1:0]  BR_result;
  logic [PHY_W-1:0] BR_result_dest;
  logic             BR_result_valid;
  logic [31:0]      BR_inst_num;
  logic             BPU_update_valid;
  logic [XLEN-1:0]  BPU_update_PC;
  logic             BPU_update_taken;
  logic [XLEN-1:0]  BPU_update_target;
  logic             BR_mispredict;
  logic [XLEN-1:0]  BR_redirect_PC;

  branch_resolve_unit #(.XLEN(XLEN), .PHY_W(PHY_W), .FLUSH_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .RS_BR_Branch(RS_BR_Branch), .RS_BR_Jump(RS_BR_Jump), .RS_BR_Jalr(RS_BR_Jalr),
    .RS_BR_Hit(RS_BR_Hit), .RS_BR_taken(RS_BR_taken), .RS_BR_Phy(RS_BR_Phy),
    .RS_BR_inst_num_output(RS_BR_inst_num_output), .RS_BR_funct3(RS_BR_funct3),
    .immediate_BR(immediate_BR), .Operand1_BR(Operand1_BR), .Operand2_BR(Operand2_BR),
    .PC_BR(PC_BR), .BR_result(BR_result), .BR_result_dest(BR_result_dest),
    .BR_result_valid(BR_result_valid), .BR_inst_num(BR_inst_num),
    .BPU_update_valid(BPU_update_valid), .BPU_update_PC(BPU_update_PC),
    .BPU_update_taken(BPU_update_taken), .BPU_update_target(BPU_update_target),
    .BR_mispredict(BR_mispredict), .BR_redirect_PC(BR_redirect_PC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tag;
    logic [31:0] target;
    logic [31:0] redirect;
    logic [31:0] link;
    logic [7:0]  phy;
    logic        taken;
    logic        mp;
    logic        rv;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          flush_left = 0;
  logic [31:0] flush_redir = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one branch/jump.
  function automatic exp_t model(input logic br, input logic jmp, input logic jalr,
                                 input logic hit, input logic pt, input logic [7:0] phy,
                                 input logic [31:0] tag, input logic [2:0] f3,
                                 input logic [31:0] imm, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] pc);
    exp_t e;
    logic c;
    case (f3)
      3'd0:    c = (a == b);
      3'd1:    c = (a != b);
      3'd4:    c = ($signed(a) < $signed(b));
      3'd5:    c = !($signed(a) < $signed(b));
      3'd6:    c = (a < b);
      3'd7:    c = !(a < b);
      default: c = 1'b0;
    endcase
    e.taken    = jmp ? 1'b1 : (br & c);
    e.target   = (jmp && jalr) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.link     = pc + 32'd4;
    e.redirect = e.taken ? e.target : e.link;
    e.mp       = (e.taken != (hit & pt));
    e.rv       = jmp && (phy != 8'd0);
    e.pc       = pc;
    e.tag      = tag;
    e.phy      = phy;
    e.due      = 0;
    return e;
  endfunction

  // Compare DUT outputs against the scoreboard and the flush model.
  task automatic monitor();
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("bpu_valid", 32'(BPU_update_valid), 32'd1);
      chk("bpu_pc", BPU_update_PC, e.pc);
      chk("bpu_taken", 32'(BPU_update_taken), 32'(e.taken));
      chk("bpu_target", BPU_update_target, e.target);
      chk("inst_num", BR_inst_num, e.tag);
      chk("result_valid", 32'(BR_result_valid), 32'(e.rv));
      if (e.rv) begin
        chk("result", BR_result, e.link);
        chk("result_dest", 32'(BR_result_dest), 32'(e.phy));
      end
      if (e.mp) begin
        flush_left  = HOLD;
        flush_redir = e.redirect;
      end
    end else begin
      chk("no_strobe", {30'd0, BPU_update_valid, BR_result_valid}, 32'd0);
    end
    chk("mispredict", 32'(BR_mispredict), 32'(flush_left > 0));
    if (flush_left > 0) begin
      chk("redirect", BR_redirect_PC, flush_redir);
      flush_left--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic br, input logic jmp, input logic jalr, input logic hit,
                       input logic pt, input logic [7:0] phy, input logic [31:0] tag,
                       input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic live);
    exp_t e;
    issue_valid = 1'b1;
    RS_BR_Branch = br; RS_BR_Jump = jmp; RS_BR_Jalr = jalr;
    RS_BR_Hit = hit; RS_BR_taken = pt; RS_BR_Phy = phy;
    RS_BR_inst_num_output = tag; RS_BR_funct3 = f3;
    immediate_BR = imm; Operand1_BR = a; Operand2_BR = b; PC_BR = pc;
    if (live && (br || jmp)) begin
      e = model(br, jmp, jalr, hit, pt, phy, tag, f3, imm, a, b, pc);
      e.due = cyc + 2;
      sb.push_back(e);
    end
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_result"}, BR_result, 32'd0);
    chk({tag, "_dest"}, 32'(BR_result_dest), 32'd0);
    chk({tag, "_rvalid"}, 32'(BR_result_valid), 32'd0);
    chk({tag, "_inst"}, BR_inst_num, 32'd0);
    chk({tag, "_bvalid"}, 32'(BPU_update_valid), 32'd0);
    chk({tag, "_bpc"}, BPU_update_PC, 32'd0);
    chk({tag, "_btaken"}, 32'(BPU_update_taken), 32'd0);
    chk({tag, "_btarget"}, BPU_update_target, 32'd0);
    chk({tag, "_mp"}, 32'(BR_mispredict), 32'd0);
    chk({tag, "_redir"}, BR_redirect_PC, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; issue_valid = 1'b0;
    RS_BR_Branch = 0; RS_BR_Jump = 0; RS_BR_Jalr = 0; RS_BR_Hit = 0; RS_BR_taken = 0;
    RS_BR_Phy = '0; RS_BR_inst_num_output = '0; RS_BR_funct3 = '0;
    immediate_BR = '0; Operand1_BR = '0; Operand2_BR = '0; PC_BR = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    idle(2);

    // BEQ taken, not predicted: flush to PC+imm
    issue(1, 0, 0, 0, 0, 8'd0, 32'd1, 3'd0, 32'h20, 32'd5, 32'd5, 32'h100, 1);
    idle(4);

    // BLT signed taken (predicted), then BLTU not taken (mispredicted)
    issue(1, 0, 0, 1, 1, 8'd0, 32'd2, 3'd4, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h300, 1);
    issue(1, 0, 0, 1, 1, 8'd0, 32'd3, 3'd6, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h310, 1);
    idle(4);

    // JALR with odd base: link writeback and target LSB cleared
    issue(0, 1, 1, 0, 0, 8'd5, 32'd4, 3'd0, 32'd4, 32'h1003, 32'd0, 32'h200, 1);
    idle(4);

    // Mispredict on tag 10; younger tags killed, older tag 9 resolves
    issue(1, 0, 0, 0, 0, 8'd0, 32'd10, 3'd1, 32'h80, 32'd1, 32'd2, 32'h400, 1);
    issue(1, 0, 0, 0, 0, 8'd0, 32'd11, 3'd0, 32'h10, 32'd1, 32'd1, 32'h404, 0);
    issue(1, 0, 0, 0, 0, 8'd0, 32'd9, 3'd0, 32'h10, 32'd1, 32'd2, 32'h3FC, 1);
    issue(0, 1, 0, 0, 0, 8'd7, 32'd12, 3'd0, 32'h10, 32'd0, 32'd0, 32'h408, 0);
    idle(4);

    // Older mispredict during flush replaces redirect and reloads the hold;
    // a same-cycle issue younger than the new tag is killed
    issue(0, 1, 0, 0, 0, 8'd3, 32'd20, 3'd0, 32'h10, 32'd0, 32'd0, 32'h500, 1);
    issue(1, 0, 0, 0, 0, 8'd0, 32'd15, 3'd0, 32'h8, 32'd7, 32'd7, 32'h600, 1);
    issue(1, 0, 0, 0, 0, 8'd0, 32'd16, 3'd0, 32'h8, 32'd7, 32'd7, 32'h604, 0);
    idle(5);

    // JAL to x0, correctly predicted; non-branch issue dropped; funct3 010 not taken
    issue(0, 1, 0, 1, 1, 8'd0, 32'd30, 3'd0, 32'h100, 32'd0, 32'd0, 32'h700, 1);
    issue(0, 0, 0, 0, 0, 8'd4, 32'd31, 3'd0, 32'h10, 32'd0, 32'd0, 32'h704, 1);
    issue(1, 0, 0, 0, 0, 8'd0, 32'd32, 3'd2, 32'h10, 32'd3, 32'd3, 32'h708, 1);
    idle(3);

    // Reset during flush aborts it; next issue resolves normally
    issue(1, 0, 0, 0, 0, 8'd0, 32'd40, 3'd0, 32'h30, 32'd9, 32'd9, 32'h800, 1);
    tick();
    chk("flush_active", 32'(BR_mispredict), 32'd1);
    reset = 1'b1;
    sb.delete();
    flush_left = 0;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    issue(1, 0, 0, 1, 1, 8'd0, 32'd41, 3'd5, 32'h24, 32'd3, 32'hFFFF_FFFE, 32'h900, 1);
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
